// File: rtl/ddr_arbiter.sv
// ============================================================================
//  Module      : ddr_arbiter
//  Description : Two-port round-robin arbiter that sequences single 32-bit
//                read/write requests onto the ddr_controller user command port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr_arbiter #(
    parameter logic [3:0]  CMD_WRITE = 4'h1,
    parameter logic [3:0]  CMD_READ  = 4'h2,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [23:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_done,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [23:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_done,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic [3:0]  usr_cmd,
    output logic        usr_cmd_vld,
    output logic [23:0] usr_addr,
    output logic [31:0] usr_data_in,
    input  logic [31:0] usr_data_out,
    input  logic        usr_data_out_vld,
    input  logic        ddr_busy,
    input  logic        ddr_ack,
    input  logic        ddr_ready,
    output logic        arb_busy
);

    localparam int                  c_tmr_w    = $clog2(TIMEOUT) + 1;
    localparam logic [c_tmr_w-1:0]  c_tmr_last = c_tmr_w'(TIMEOUT - 1);
    localparam logic [c_tmr_w-1:0]  c_tmr_one  = c_tmr_w'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_RD = 3'd2,
        S_DONE    = 3'd3,
        S_ERR     = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                we_q, we_d;
    logic [23:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [c_tmr_w-1:0]  tmr_q, tmr_d;
    logic [31:0]         rdata0_q, rdata0_d;
    logic [31:0]         rdata1_q, rdata1_d;
    logic                w_win;
    logic                w_capture;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            gnt_q    <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            tmr_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            tmr_q    <= tmr_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tmr_d     = '0;
        w_win     = 1'b0;
        w_capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ddr_ready && !ddr_busy && (r0_req || r1_req)) begin
                    // On a tie the port that did not win last time goes next
                    w_win   = (r0_req && r1_req) ? ~gnt_q : r1_req;
                    gnt_d   = w_win;
                    we_d    = w_win ? r1_we    : r0_we;
                    addr_d  = w_win ? r1_addr  : r0_addr;
                    wdata_d = w_win ? r1_wdata : r0_wdata;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmr_d = tmr_q + c_tmr_one;
                if (tmr_q == c_tmr_last) begin
                    state_d = S_ERR;
                end else if (ddr_ack) begin
                    if (we_q) begin
                        state_d = S_DONE;
                    end else if (usr_data_out_vld) begin
                        w_capture = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                tmr_d = tmr_q + c_tmr_one;
                if (tmr_q == c_tmr_last) begin
                    state_d = S_ERR;
                end else if (usr_data_out_vld) begin
                    w_capture = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Only the granted port's read-data register moves; the other keeps its last value
    always_comb begin
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        if (w_capture) begin
            if (gnt_q) rdata1_d = usr_data_out;
            else       rdata0_d = usr_data_out;
        end
    end

    assign usr_cmd_vld = (state_q == S_ISSUE);
    assign usr_cmd     = usr_cmd_vld ? (we_q ? CMD_WRITE : CMD_READ) : 4'h0;
    assign usr_addr    = addr_q;
    assign usr_data_in = wdata_q;
    assign arb_busy    = (state_q != S_IDLE);

    assign r0_done  = (state_q == S_DONE) && !gnt_q;
    assign r1_done  = (state_q == S_DONE) &&  gnt_q;
    assign r0_err   = (state_q == S_ERR)  && !gnt_q;
    assign r1_err   = (state_q == S_ERR)  &&  gnt_q;
    assign r0_rdata = rdata0_q;
    assign r1_rdata = rdata1_q;

endmodule

`default_nettype wire
